// File: rtl/add_8bit_if.sv
// Operand/result bundle for the registered 8-bit adder.
// The master drives operands and observes the registered result; the slave is the adder.
interface add_8bit_if;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       in_vld;
    logic [7:0] sum;
    logic       cout;
    logic       ov;
    logic       out_vld;

    modport master (
        output a, b, cin, in_vld,
        input  sum, cout, ov, out_vld
    );

    modport slave (
        input  a, b, cin, in_vld,
        output sum, cout, ov, out_vld
    );
endinterface

// File: rtl/add_8bit.sv
// Registered 8-bit adder with carry-in, carry-out and signed overflow.
// The core is an explicit ripple chain so the carries into and out of bit 7 are both available for ov.
module add_8bit (
    input  logic        clk,
    input  logic        rst_n,
    add_8bit_if.slave   bus
);
    localparam int unsigned W = 8;

    logic [W:0]   carry;
    logic [W-1:0] sum_c;
    logic         cout_c;
    logic         ov_c;

    // Ripple-carry chain of full-adder cells
    always_comb begin
        carry    = '0;
        sum_c    = '0;
        carry[0] = bus.cin;
        for (int i = 0; i < int'(W); i++) begin
            sum_c[i]   = bus.a[i] ^ bus.b[i] ^ carry[i];
            carry[i+1] = (bus.a[i] & bus.b[i]) | (carry[i] & (bus.a[i] ^ bus.b[i]));
        end
        cout_c = carry[W];
        ov_c   = carry[W] ^ carry[W-1];
    end

    // Result registers hold their value while no operation is offered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.sum     <= '0;
            bus.cout    <= 1'b0;
            bus.ov      <= 1'b0;
            bus.out_vld <= 1'b0;
        end else begin
            bus.out_vld <= bus.in_vld;
            if (bus.in_vld) begin
                bus.sum  <= sum_c;
                bus.cout <= cout_c;
                bus.ov   <= ov_c;
            end
        end
    end
endmodule

// File: tb/tb_add_8bit.sv
// Self-checking bench for add_8bit: directed vector table, hold/back-to-back and reset sequences,
// and a random sweep against an arithmetic reference model.
module tb_add_8bit;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;

    add_8bit_if bus ();

    add_8bit u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] e_sum;
        logic       e_cout;
        logic       e_ov;
    } vec_t;

    vec_t vecs[9];

    // Expected values of the last accepted operation (reset clears them)
    logic [7:0] m_sum;
    logic       m_cout;
    logic       m_ov;

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] es, input logic ec,
                           input logic eo, input logic ev);
        chk({tag, ".sum"},     bus.sum,            es);
        chk({tag, ".cout"},    8'(bus.cout),       8'(ec));
        chk({tag, ".ov"},      8'(bus.ov),         8'(eo));
        chk({tag, ".out_vld"}, 8'(bus.out_vld),    8'(ev));
    endtask

    // Reference: plain integer arithmetic, unsigned for sum/cout, signed range for ov
    task automatic ref_add(input logic [7:0] a, input logic [7:0] b, input logic cin,
                           output logic [7:0] s, output logic co, output logic ov);
        int u;
        int sr;
        u  = int'(a) + int'(b) + int'(cin);
        sr = int'($signed(a)) + int'($signed(b)) + int'(cin);
        s  = 8'(u % 256);
        co = (u > 255);
        ov = (sr > 127) || (sr < -128);
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic vld);
        bus.a      = a;
        bus.b      = b;
        bus.cin    = cin;
        bus.in_vld = vld;
    endtask

    initial begin
        logic [7:0] ra, rb, es;
        logic       rc, rv, ec, eo;

        n_checks = 0;
        n_err    = 0;
        vecs[0] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h11, 1'b0, 8'h10, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
        vecs[6] = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};
        vecs[7] = '{8'h01, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[8] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        // Reset with garbage on the inputs and the clock running
        rst_n = 1'b1;
        drive(8'h3C, 8'hC3, 1'b1, 1'b1);
        #1 rst_n = 1'b0;
        #1 chk_all("reset_imm", 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 chk_all("reset_hold", 8'h00, 1'b0, 1'b0, 1'b0);
            drive(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
        end
        @(negedge clk);
        drive(8'h00, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1);
            @(posedge clk);
            #1 chk_all($sformatf("vec%0d", i), vecs[i].e_sum, vecs[i].e_cout, vecs[i].e_ov, 1'b1);
        end

        // Back-to-back then idle: results in order, then hold the last one
        @(negedge clk); drive(8'h10, 8'h20, 1'b0, 1'b1);
        @(posedge clk); #1 chk_all("b2b0", 8'h30, 1'b0, 1'b0, 1'b1);
        @(negedge clk); drive(8'h7F, 8'h7F, 1'b1, 1'b1);
        @(posedge clk); #1 chk_all("b2b1", 8'hFF, 1'b0, 1'b1, 1'b1);
        @(negedge clk); drive(8'hF0, 8'h20, 1'b0, 1'b1);
        @(posedge clk); #1 chk_all("b2b2", 8'h10, 1'b1, 1'b0, 1'b1);
        @(negedge clk); drive(8'h01, 8'h01, 1'b1, 1'b0);
        @(posedge clk); #1 chk_all("hold0", 8'h10, 1'b1, 1'b0, 1'b0);
        @(negedge clk); drive(8'h80, 8'h80, 1'b0, 1'b0);
        @(posedge clk); #1 chk_all("hold1", 8'h10, 1'b1, 1'b0, 1'b0);

        // Random sweep against the reference model
        m_sum  = 8'h10;
        m_cout = 1'b1;
        m_ov   = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            rv = ($urandom_range(0, 3) != 0);
            drive(ra, rb, rc, rv);
            if (rv) begin
                ref_add(ra, rb, rc, es, ec, eo);
                m_sum  = es;
                m_cout = ec;
                m_ov   = eo;
            end
            @(posedge clk);
            #1 chk_all("rand", m_sum, m_cout, m_ov, rv);
        end

        // Reset asserted between edges discards the held result immediately
        @(negedge clk); drive(8'h12, 8'h34, 1'b0, 1'b1);
        @(posedge clk); #1 chk_all("pre_rst", 8'h46, 1'b0, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk_all("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1 chk_all("mid_rst_hold", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(8'h7F, 8'h00, 1'b1, 1'b1);
        @(posedge clk); #1 chk_all("post_rst", 8'h80, 1'b0, 1'b1, 1'b1);
        @(negedge clk); drive(8'h00, 8'h00, 1'b0, 1'b0);
        @(posedge clk); #1 chk_all("post_rst_idle", 8'h80, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
